alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Arbitrated, pipelined front-end that shares one 12-bit combinational ALU between two requesters.
- ALU interface: op_select 0=abs, 1=shl, 2=and, 3=or, 4=xor, 5=not, 6=add, 7=sub; outputs out, cout, sign, overflow.
- Accepts operation requests over valid/ready, grants round-robin, and drives registered operands to the ALU.
- Captures result and flags, then returns them on one shared response channel tagged with the requester id.
- Sits between the control sequencer ports and the ALU instance; the ALU stays outside this block.

Parameters:
WIDTH, 12, operand/result width; must match the ALU.
OPW, 3, op_select width.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 transfer accepted this cycle
req0_op  input  OPW  requester 0 op_select
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
alu_a  output  WIDTH  registered operand a to ALU
alu_b  output  WIDTH  registered operand b to ALU
alu_op  output  OPW  registered op_select to ALU
alu_out  input  WIDTH  ALU result
alu_cout  input  1  ALU carry
alu_sign  input  1  ALU sign
alu_overflow  input  1  ALU overflow
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued the op
rsp_data  output  WIDTH  captured result
rsp_cout, rsp_sign, rsp_ovf  output  1 each  captured flags
busy  output  1  high in any state other than IDLE

Behaviour:
- States: INIT, IDLE, EXEC, RESP. Reset (async, rst_n low) forces INIT.
- Reset values: alu_a, alu_b, alu_op, rsp_data, rsp_id, and all rsp flags are 0; rsp_valid is 0; busy is 1 (state INIT).
- INIT -> IDLE unconditionally on the first clk edge after rst_n rises.
- reqN_ready is combinational: (state==IDLE) && reqN_valid && grant==N. Both readys are 0 outside IDLE, so they are 0 during reset.
- Arbitration:
  - last_grant register resets to 1.
  - If both requesters are valid, grant = ~last_grant; otherwise grant goes to the single valid requester.
  - last_grant updates only on an accepted transfer.
- Transfer: IDLE with ready high at edge T latches op/a/b into alu_op/alu_a/alu_b and the id into rsp_id. State -> EXEC.
- EXEC, one cycle: at edge T+1, register alu_out/alu_cout/alu_sign/alu_overflow into rsp_data/rsp_cout/rsp_sign/rsp_ovf, set rsp_valid=1. State -> RESP.
- RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid; state -> IDLE.
- Latency: request accepted at edge T, response visible after edge T+1. Minimum spacing between accepts is 3 cycles.
- alu_a/alu_b/alu_op hold their last values after EXEC; they do not return to 0.
- Flags pass through raw; the controller performs no interpretation per opcode.
- Requests must hold valid and data until ready; a valid that drops before ready is dropped with no side effect.
- Reset mid-operation: the in-flight op and any pending response are discarded; rsp_valid goes to 0 immediately (async).

Optional Feature:
- Macro: ALU_SHARE_STICKY_OVF_EN.
- Defined:
  - Adds input ovf_clr (1) and outputs ovf_sticky0, ovf_sticky1 (1 each).
  - ovf_stickyN is set at the EXEC capture edge when alu_overflow=1 and rsp_id==N.
  - ovf_clr clears both sticky bits; a set and a clear on the same edge resolve to set.
  - Both bits reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, req0 add 0x60F+0x061 (op 6) -> req0_ready in the first IDLE cycle; rsp_valid after 2 edges; rsp_id=0, rsp_data=0x670, rsp_ovf=0.
- req1 add 0x69F+0x769 -> rsp_data=0xE08, rsp_ovf=1, rsp_id=1; with the macro defined, ovf_sticky1=1 and ovf_sticky0=0.
- Both valid continuously, 4 ops -> grants in order 0,1,0,1, each rsp_id matching.
- rsp_ready held low 5 cycles with req0 valid -> rsp_* stable, req0_ready=0; accept the next op the cycle after rsp_ready rises.
- rst_n pulsed low while in EXEC -> rsp_valid=0 and outputs at reset values; one INIT cycle before ready returns.
- req0 sub 0x815-0x76B (op 7) -> rsp_data=0x0AA, rsp_ovf=1.

Source files
------------

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one external combinational ALU between two requesters.
//               It arbitrates round-robin over valid/ready, registers the
//               granted operands toward the ALU, captures the result and
//               flags one cycle later, and holds them on a single response
//               channel tagged with the requester id until it is consumed.
// Ports       : clk, rst_n (async, active low)
//               req0_* / req1_* : valid, ready, op, a, b per requester
//               alu_a, alu_b, alu_op : registered operands to the ALU
//               alu_out, alu_cout, alu_sign, alu_overflow : ALU results
//               rsp_valid/ready, rsp_id, rsp_data, rsp_cout/sign/ovf
//               busy : high whenever the controller is not IDLE
// Options     : ALU_SHARE_STICKY_OVF_EN adds ovf_clr, ovf_sticky0 and
//               ovf_sticky1 (per-requester sticky overflow bits)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl #(
  parameter int WIDTH = 12,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_sign,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_sign,
  output logic             rsp_ovf,
  output logic             busy
`ifdef ALU_SHARE_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky0,
  output logic             ovf_sticky1
`endif
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   grant;
  logic   accept;
  logic   rsp_take;

  // With both requesters valid the one not served last wins; otherwise the
  // single valid requester (or 0 when neither is valid, which is harmless
  // because ready is also qualified by valid).
  assign grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && (grant == 1'b0);
  assign req1_ready = (state == IDLE) && req1_valid && (grant == 1'b1);
  assign accept     = req0_ready || req1_ready;
  assign rsp_take   = (state == RESP) && rsp_valid && rsp_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = IDLE;
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_take) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Operand/response datapath. Operands are left untouched after EXEC so
  // the ALU inputs only toggle on a new transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
      rsp_sign   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_valid  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_a      <= grant ? req1_a  : req0_a;
        alu_b      <= grant ? req1_b  : req0_b;
        alu_op     <= grant ? req1_op : req0_op;
        rsp_id     <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_cout  <= alu_cout;
        rsp_sign  <= alu_sign;
        rsp_ovf   <= alu_overflow;
        rsp_valid <= 1'b1;
      end else if (rsp_take) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SHARE_STICKY_OVF_EN
  // Set has priority over clear so an overflow landing on the clear edge
  // is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky0 <= 1'b0;
      ovf_sticky1 <= 1'b0;
    end else begin
      if ((state == EXEC) && alu_overflow && (rsp_id == 1'b0)) begin
        ovf_sticky0 <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky0 <= 1'b0;
      end
      if ((state == EXEC) && alu_overflow && (rsp_id == 1'b1)) begin
        ovf_sticky1 <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky1 <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Directed self-checking bench for alu_share_ctrl. A small
//               behavioural ALU closes the loop on the alu_* ports; all
//               expected results are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

  localparam int WIDTH = 12;
  localparam int OPW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0]   req0_op, req1_op, alu_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [WIDTH-1:0] alu_out, rsp_data;
  logic             alu_cout, alu_sign, alu_overflow;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_sign, rsp_ovf;
  logic             busy;
`ifdef ALU_SHARE_STICKY_OVF_EN
  logic             ovf_clr, ovf_sticky0, ovf_sticky1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_sign(alu_sign),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_sign(rsp_sign),
    .rsp_ovf(rsp_ovf), .busy(busy)
`ifdef ALU_SHARE_STICKY_OVF_EN
    , .ovf_clr(ovf_clr), .ovf_sticky0(ovf_sticky0), .ovf_sticky1(ovf_sticky1)
`endif
  );

  // Behavioural 12-bit ALU
  logic [WIDTH:0] wide;
  always_comb begin
    wide         = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        wide[WIDTH-1:0] = alu_a[WIDTH-1] ? (~alu_a + 1'b1) : alu_a;
        alu_overflow    = (alu_a == 12'h800);
      end
      3'd1: begin
        wide         = {alu_a, 1'b0};
        alu_overflow = alu_a[WIDTH-1] ^ alu_a[WIDTH-2];
      end
      3'd2: wide[WIDTH-1:0] = alu_a & alu_b;
      3'd3: wide[WIDTH-1:0] = alu_a | alu_b;
      3'd4: wide[WIDTH-1:0] = alu_a ^ alu_b;
      3'd5: wide[WIDTH-1:0] = ~alu_a;
      3'd6: begin
        wide         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                       (wide[WIDTH-1] != alu_a[WIDTH-1]);
      end
      default: begin
        wide         = {1'b0, alu_a} - {1'b0, alu_b};
        alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                       (wide[WIDTH-1] != alu_a[WIDTH-1]);
      end
    endcase
    alu_out  = wide[WIDTH-1:0];
    alu_cout = wide[WIDTH];
    alu_sign = wide[WIDTH-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic [2:0] op,
                       input logic [11:0] a, input logic [11:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Takes the accepting edge, drops requests, checks registered operands.
  task automatic accept_chk(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("alu_op", alu_op, op);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("busy_exec", busy, 1);
    check("rsp_valid_exec", rsp_valid, 0);
  endtask

  // Capture edge, then one handshake to drain the response.
  task automatic finish_rsp(input logic id, input logic [11:0] data, input logic ovf);
    @(posedge clk); #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_data", rsp_data, data);
    check("rsp_ovf", rsp_ovf, ovf);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_drain", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  task automatic issue(input logic id, input logic [2:0] op,
                       input logic [11:0] a, input logic [11:0] b);
    logic got;
    got = 1'b0;
    drive(id, op, a, b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_wait", got, 1);
    if (got) accept_chk(op, a, b);
  endtask

  task automatic run_op(input logic id, input logic [2:0] op, input logic [11:0] a,
                        input logic [11:0] b, input logic [11:0] data, input logic ovf);
    issue(id, op, a, b);
    finish_rsp(id, data, ovf);
  endtask

  initial begin
    logic [11:0] exp_d;
    logic        got;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
`ifdef ALU_SHARE_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif

    // Reset state, with a request already pending
    drive(0, 3'd6, 12'h60F, 12'h061);
    #3;
    check("rst_busy", busy, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("init_ready", req0_ready, 0);
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("first_idle_ready", req0_ready, 1);
    accept_chk(3'd6, 12'h60F, 12'h061);
    finish_rsp(0, 12'h670, 0);

    // Signed overflow on requester 1
    run_op(1, 3'd6, 12'h69F, 12'h769, 12'hE08, 1);
`ifdef ALU_SHARE_STICKY_OVF_EN
    check("sticky1", ovf_sticky1, 1);
    check("sticky0", ovf_sticky0, 0);
`endif

    // Both requesters valid continuously: alternate 0,1,0,1
    drive(0, 3'd2, 12'hF0F, 12'h0FF);
    drive(1, 3'd4, 12'hF0F, 12'h0FF);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          break;
        end
      end
      check("rr_wait", got, 1);
      check("rr_grant", req1_ready, k % 2);
      @(posedge clk); #1;
      exp_d = (k % 2) ? 12'hFF0 : 12'h00F;
      finish_rsp(k % 2, exp_d, 0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure: response held while a new request waits
    issue(1, 3'd5, 12'h0F0, 12'h000);
    @(posedge clk); #1;
    check("bp_valid", rsp_valid, 1);
    drive(0, 3'd6, 12'h60F, 12'h061);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 12'hF0F);
      check("bp_hold_id", rsp_id, 1);
      check("bp_req0_ready", req0_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", rsp_valid, 0);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_next_ready", req0_ready, 1);
    accept_chk(3'd6, 12'h60F, 12'h061);
    finish_rsp(0, 12'h670, 0);

    // Asynchronous reset while in EXEC
    issue(0, 3'd2, 12'hABC, 12'h0F0);
    drive(0, 3'd2, 12'hABC, 12'h0F0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_op", alu_op, 0);
    check("mid_rst_ready", req0_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("mid_rst_init", req0_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("mid_rst_ready_back", req0_ready, 1);
    accept_chk(3'd2, 12'hABC, 12'h0F0);
    finish_rsp(0, 12'h0B0, 0);

    // Subtraction with signed overflow
    run_op(0, 3'd7, 12'h815, 12'h76B, 12'h0AA, 1);
`ifdef ALU_SHARE_STICKY_OVF_EN
    check("sticky0_set", ovf_sticky0, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("sticky0_clr", ovf_sticky0, 0);
    check("sticky1_clr", ovf_sticky1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck handshake still ends the run
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
